// File: rtl/spi_bus_bridge.sv
// SPI mode-0 slave front end: oversamples sclk/cs_n/mosi in the clk domain, deserialises
// MOSI into words for the array controller and serialises one buffered result word onto MISO.
module spi_bus_bridge #(
   parameter int WORD_SIZE   = 16,
   parameter int VALID_HOLD  = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 sclk,
   input  logic                 cs_n,
   input  logic                 mosi,
   output logic                 miso,
   output logic                 spi_2_bus_valid,
   output logic [WORD_SIZE-1:0] spi_2_bus_data,
   input  logic                 bus_2_spi_valid,
   input  logic [WORD_SIZE-1:0] bus_2_spi_data,
   output logic                 bus_2_spi_ready,
   output logic                 rx_overrun,
   output logic                 tx_overrun
);

   localparam int BW = $clog2(WORD_SIZE);
   localparam int HW = $clog2(VALID_HOLD);

   logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q;
   logic                   sclk_prev_q, cs_prev_q, bvld_q;
   logic [BW-1:0]          bit_cnt_q, bit_cnt_d;
   logic [WORD_SIZE-1:0]   rx_shift_q, rx_shift_d;
   logic [WORD_SIZE-1:0]   tx_shift_q, tx_shift_d;
   logic [WORD_SIZE-1:0]   tx_buf_q, tx_buf_d;
   logic                   tx_buf_full_q, tx_buf_full_d;
   logic                   ready_q, ready_d;
   logic                   valid_q, valid_d;
   logic [WORD_SIZE-1:0]   data_q, data_d;
   logic [HW-1:0]          hold_q, hold_d;
   logic                   rx_ovr_q, rx_ovr_d;
   logic                   tx_ovr_q, tx_ovr_d;

   logic s_sclk, s_cs, s_mosi;
   logic sclk_rise, sclk_fall, cs_act, cs_fall, bvld_rise, load;

   assign s_sclk    = sclk_sync_q[SYNC_STAGES-1];
   assign s_cs      = cs_sync_q[SYNC_STAGES-1];
   assign s_mosi    = mosi_sync_q[SYNC_STAGES-1];
   assign sclk_rise = s_sclk & ~sclk_prev_q;
   assign sclk_fall = ~s_sclk & sclk_prev_q;
   assign cs_act    = ~s_cs;
   assign cs_fall   = cs_act & cs_prev_q;
   assign bvld_rise = bus_2_spi_valid & ~bvld_q;

   always_comb begin
      bit_cnt_d     = bit_cnt_q;
      rx_shift_d    = rx_shift_q;
      tx_shift_d    = tx_shift_q;
      tx_buf_d      = tx_buf_q;
      tx_buf_full_d = tx_buf_full_q;
      valid_d       = valid_q;
      data_d        = data_q;
      hold_d        = hold_q;
      rx_ovr_d      = rx_ovr_q;
      tx_ovr_d      = tx_ovr_q;
      ready_d       = ~tx_buf_full_q;
      load          = 1'b0;

      if (valid_q) begin
         if (hold_q == '0) valid_d = 1'b0;
         else              hold_d  = hold_q - 1'b1;
      end

      if (!cs_act) begin
         // deselected: drop any partial word so the next frame starts on a word boundary
         bit_cnt_d  = '0;
         rx_shift_d = '0;
      end else begin
         if (cs_fall) load = 1'b1;
         if (sclk_rise) begin
            rx_shift_d = {rx_shift_q[WORD_SIZE-2:0], s_mosi};
            if (bit_cnt_q == BW'(WORD_SIZE - 1)) begin
               bit_cnt_d = '0;
               data_d    = {rx_shift_q[WORD_SIZE-2:0], s_mosi};
               valid_d   = 1'b1;
               hold_d    = HW'(VALID_HOLD - 1);
               if (valid_q) rx_ovr_d = 1'b1;
            end else begin
               bit_cnt_d = bit_cnt_q + 1'b1;
            end
         end
         if (sclk_fall) begin
            if (bit_cnt_q != '0) tx_shift_d = tx_shift_q << 1;
            else                 load       = 1'b1;
         end
      end

      if (load) begin
         tx_shift_d    = tx_buf_full_q ? tx_buf_q : '0;
         tx_buf_full_d = 1'b0;
      end

      // a reload in this cycle has already emptied the buffer, so the new word is kept
      if (bvld_rise) begin
         if (!tx_buf_full_q || load) begin
            tx_buf_d      = bus_2_spi_data;
            tx_buf_full_d = 1'b1;
         end else begin
            tx_ovr_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sclk_sync_q   <= '0;
         cs_sync_q     <= '1;
         mosi_sync_q   <= '0;
         sclk_prev_q   <= 1'b0;
         cs_prev_q     <= 1'b1;
         bvld_q        <= 1'b0;
         bit_cnt_q     <= '0;
         rx_shift_q    <= '0;
         tx_shift_q    <= '0;
         tx_buf_q      <= '0;
         tx_buf_full_q <= 1'b0;
         ready_q       <= 1'b0;
         valid_q       <= 1'b0;
         data_q        <= '0;
         hold_q        <= '0;
         rx_ovr_q      <= 1'b0;
         tx_ovr_q      <= 1'b0;
      end else begin
         sclk_sync_q   <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
         cs_sync_q     <= {cs_sync_q[SYNC_STAGES-2:0], cs_n};
         mosi_sync_q   <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
         sclk_prev_q   <= s_sclk;
         cs_prev_q     <= s_cs;
         bvld_q        <= bus_2_spi_valid;
         bit_cnt_q     <= bit_cnt_d;
         rx_shift_q    <= rx_shift_d;
         tx_shift_q    <= tx_shift_d;
         tx_buf_q      <= tx_buf_d;
         tx_buf_full_q <= tx_buf_full_d;
         ready_q       <= ready_d;
         valid_q       <= valid_d;
         data_q        <= data_d;
         hold_q        <= hold_d;
         rx_ovr_q      <= rx_ovr_d;
         tx_ovr_q      <= tx_ovr_d;
      end
   end

   assign miso            = cs_act & tx_shift_q[WORD_SIZE-1];
   assign spi_2_bus_valid = valid_q;
   assign spi_2_bus_data  = data_q;
   assign bus_2_spi_ready = ready_q;
   assign rx_overrun      = rx_ovr_q;
   assign tx_overrun      = tx_ovr_q;

endmodule
